// File: rtl/wb_ram_xbar.sv
// wb_ram_xbar: pipelined Wishbone crossbar from NUM_PORTS slave ports onto
// NUM_BANKS word-wide RAM banks. Each bank owns an arbiter, so requests to
// different banks are served in the same cycle; losers see stall.
// Reads and writes ack one cycle after acceptance with write-first data.
module wb_ram_xbar #(
   parameter  int NUM_PORTS = 2,
   parameter  int NUM_BANKS = 2,
   parameter  int BANK_AW   = 8,
   parameter  int ARB_MODE  = 0,
   localparam int BSW       = $clog2(NUM_BANKS),
   localparam int AW        = BSW + BANK_AW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    wb_stb_i,
   input  logic [NUM_PORTS*AW-1:0] wb_addr_i,
   input  logic [NUM_PORTS*4-1:0]  wb_we_i,
   input  logic [NUM_PORTS*32-1:0] wb_data_i,
   output logic [NUM_PORTS-1:0]    wb_ack_o,
   output logic [NUM_PORTS-1:0]    wb_stall_o,
   output logic [NUM_PORTS*32-1:0] wb_data_o
);

   localparam int PW    = $clog2(NUM_PORTS);
   localparam int DEPTH = 2 ** BANK_AW;

   // Byte-lane merge: lanes with we set take the new byte, others keep the old.
   function automatic logic [31:0] f_merge(input logic [31:0] i_old,
                                           input logic [31:0] i_new,
                                           input logic [3:0]  i_we);
      logic [31:0] v_res;
      v_res = i_old;
      for (int b = 0; b < 4; b++) begin
         v_res[8*b +: 8] = i_we[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
      end
      return v_res;
   endfunction

   // Per-port decoded request fields
   logic [BSW-1:0]       w_bank   [NUM_PORTS];
   logic [BANK_AW-1:0]   w_word   [NUM_PORTS];
   logic [3:0]           w_we     [NUM_PORTS];
   logic [31:0]          w_wdat   [NUM_PORTS];
   logic [31:0]          w_merged [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_gnt;

   // Per-bank arbitration
   logic [NUM_PORTS-1:0] w_req    [NUM_BANKS];
   logic [NUM_BANKS-1:0] w_gvalid;
   logic [PW-1:0]        w_gidx   [NUM_BANKS];
   logic [PW-1:0]        r_ptr    [NUM_BANKS];

   // Storage and registered responses
   logic [31:0]          r_mem    [NUM_BANKS][DEPTH];
   logic [NUM_PORTS-1:0] r_ack;
   logic [31:0]          r_data   [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign w_bank[p]   = wb_addr_i[p*AW + BANK_AW +: BSW];
      assign w_word[p]   = wb_addr_i[p*AW +: BANK_AW];
      assign w_we[p]     = wb_we_i[p*4 +: 4];
      assign w_wdat[p]   = wb_data_i[p*32 +: 32];
      // The word as it will look after this access: the response is write-first.
      assign w_merged[p] = f_merge(r_mem[w_bank[p]][w_word[p]], w_wdat[p], w_we[p]);
      // A port can only be granted by the bank it addresses.
      assign w_gnt[p]    = w_gvalid[w_bank[p]] & (w_gidx[w_bank[p]] == PW'(p));
      assign wb_stall_o[p]          = wb_stb_i[p] & ~w_gnt[p];
      assign wb_data_o[p*32 +: 32]  = r_data[p];
   end

   assign wb_ack_o = r_ack;

   // Request decode and grant selection for every bank (no grants in reset).
   always_comb begin
      int v_idx;
      v_idx = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_gidx[b] = {PW{1'b0}};
         for (int p = 0; p < NUM_PORTS; p++) begin
            w_req[b][p] = rst_n & wb_stb_i[p] & (w_bank[p] == BSW'(b));
         end
         w_gvalid[b] = |w_req[b];
         // Scan candidates from last to first priority so the first one wins.
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            v_idx     = (ARB_MODE == 0) ? int'(r_ptr[b]) + i : i;
            v_idx     = (v_idx >= NUM_PORTS) ? v_idx - NUM_PORTS : v_idx;
            w_gidx[b] = w_req[b][v_idx] ? PW'(v_idx) : w_gidx[b];
         end
      end
   end

   // Round-robin pointer: move just past each bank's grantee, hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_ptr[b] <= {PW{1'b0}};
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_gvalid[b]) begin
               r_ptr[b] <= (w_gidx[b] == PW'(NUM_PORTS - 1)) ? {PW{1'b0}}
                                                              : w_gidx[b] + PW'(1);
            end
         end
      end
   end

   // Response registers: ack follows acceptance, data only moves on ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack <= {NUM_PORTS{1'b0}};
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_data[p] <= 32'h0000_0000;
         end
      end else begin
         r_ack <= w_gnt;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
               r_data[p] <= w_merged[p];
            end
         end
      end
   end

   // Bank storage write-back of the grantee's merged word; contents survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_gvalid[b] && (w_we[w_gidx[b]] != 4'b0000)) begin
            r_mem[b][w_word[w_gidx[b]]] <= w_merged[w_gidx[b]];
         end
      end
   end

endmodule

// File: tb/tb_wb_ram_xbar.sv
// Bench for wb_ram_xbar: one round-robin and one fixed-priority instance
// (3 ports, 2 banks) driven by directed steps and a random phase, each
// compared with a behavioural model of banks, arbitration and responses.
module tb_wb_ram_xbar;

   localparam int NP  = 3;
   localparam int NB  = 2;
   localparam int BAW = 8;
   localparam int AW  = 9;

   logic clk;
   logic rst_n;

   logic [NP-1:0]    stb_b   [2];
   logic [NP*AW-1:0] addr_b  [2];
   logic [NP*4-1:0]  we_b    [2];
   logic [NP*32-1:0] wd_b    [2];
   logic [NP-1:0]    ack_b   [2];
   logic [NP-1:0]    stall_b [2];
   logic [NP*32-1:0] rd_b    [2];

   wb_ram_xbar #(.NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_AW(BAW), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .wb_stb_i(stb_b[0]), .wb_addr_i(addr_b[0]), .wb_we_i(we_b[0]), .wb_data_i(wd_b[0]),
      .wb_ack_o(ack_b[0]), .wb_stall_o(stall_b[0]), .wb_data_o(rd_b[0]));

   wb_ram_xbar #(.NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_AW(BAW), .ARB_MODE(1)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .wb_stb_i(stb_b[1]), .wb_addr_i(addr_b[1]), .wb_we_i(we_b[1]), .wb_data_i(wd_b[1]),
      .wb_ack_o(ack_b[1]), .wb_stall_o(stall_b[1]), .wb_data_o(rd_b[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requested transactions per instance/port
   logic          t_stb  [2][NP];
   logic [AW-1:0] t_addr [2][NP];
   logic [3:0]    t_we   [2][NP];
   logic [31:0]   t_wd   [2][NP];

   // Reference model
   logic [31:0] m_mem  [2][512];
   bit          m_wr   [2][512];
   int          m_ptr  [2][NB];
   logic        m_gnt  [2][NP];
   logic        m_ack  [2][NP];
   logic [31:0] m_data [2][NP];

   int n_pass, n_fail, n_total;
   int cnt [2][NP];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NP; p++) begin
            stb_b[d][p]          = t_stb[d][p];
            addr_b[d][p*AW +: AW] = t_addr[d][p];
            we_b[d][p*4 +: 4]    = t_we[d][p];
            wd_b[d][p*32 +: 32]  = t_wd[d][p];
         end
      end
   endtask

   task automatic set_both(input int p, input logic s, input logic [AW-1:0] a,
                           input logic [3:0] we, input logic [31:0] wd);
      for (int d = 0; d < 2; d++) begin
         t_stb[d][p] = s; t_addr[d][p] = a; t_we[d][p] = we; t_wd[d][p] = wd;
      end
   endtask

   // Who wins each bank this cycle, from the arbitration rules.
   task automatic model_comb();
      int idx;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NP; p++) m_gnt[d][p] = 1'b0;
         if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin m_ack[d][p] = 1'b0; m_data[d][p] = 32'h0; end
            for (int b = 0; b < NB; b++) m_ptr[d][b] = 0;
         end else begin
            for (int b = 0; b < NB; b++) begin
               for (int i = 0; i < NP; i++) begin
                  idx = (d == 0) ? (m_ptr[d][b] + i) % NP : i;
                  if (t_stb[d][idx] && (int'(t_addr[d][idx] >> BAW) == b)) begin
                     m_gnt[d][idx] = 1'b1;
                     break;
                  end
               end
            end
         end
      end
   endtask

   // Effect of the rising edge on memory, responses and pointers.
   task automatic model_edge();
      logic [31:0] v;
      int a;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NP; p++) begin
            if (!rst_n) begin
               m_ack[d][p] = 1'b0; m_data[d][p] = 32'h0;
            end else if (m_gnt[d][p]) begin
               a = int'(t_addr[d][p]);
               v = m_mem[d][a];
               for (int b = 0; b < 4; b++) if (t_we[d][p][b]) v[8*b +: 8] = t_wd[d][p][8*b +: 8];
               m_mem[d][a] = v; m_wr[d][a] = 1'b1;
               m_ack[d][p] = 1'b1; m_data[d][p] = v;
               m_ptr[d][a >> BAW] = (p + 1) % NP;
               cnt[d][p]++;
            end else begin
               m_ack[d][p] = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all(input bit with_stall);
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NP; p++) begin
            if (with_stall)
               chk($sformatf("stall d%0d p%0d", d, p), 32'(stall_b[d][p]),
                   32'(t_stb[d][p] & ~m_gnt[d][p]));
            chk($sformatf("ack d%0d p%0d", d, p), 32'(ack_b[d][p]), 32'(m_ack[d][p]));
            chk($sformatf("data d%0d p%0d", d, p), rd_b[d][p*32 +: 32], m_data[d][p]);
         end
      end
   endtask

   // One clock: stall checked before the edge, responses after it.
   task automatic step();
      apply();
      #1;
      model_comb();
      check_all(1'b1);
      @(posedge clk);
      model_edge();
      #1;
      check_all(1'b0);
   endtask

   task automatic idle_all();
      for (int p = 0; p < NP; p++) set_both(p, 1'b0, 9'h000, 4'h0, 32'h0);
   endtask

   // Random traffic that honours the hold-while-stalled rule per instance.
   task automatic rand_cycle();
      logic [AW-1:0] v_a;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NP; p++) begin
            if (!(t_stb[d][p] && !m_gnt[d][p])) begin
               v_a = AW'($urandom_range(0, 1) * 256 + $urandom_range(0, 3));
               t_stb[d][p]  = ($urandom_range(0, 9) < 7);
               t_addr[d][p] = v_a;
               t_wd[d][p]   = $urandom;
               if (!m_wr[d][v_a]) t_we[d][p] = 4'hF;
               else if ($urandom_range(0, 1) == 0) t_we[d][p] = 4'h0;
               else t_we[d][p] = 4'($urandom_range(1, 15));
            end
         end
      end
   endtask

   initial begin
      logic [NP-1:0] v_exp;
      n_pass = 0; n_fail = 0; n_total = 0;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 512; i++) m_wr[d][i] = 1'b0;
         for (int b = 0; b < NB; b++) m_ptr[d][b] = 0;
         for (int p = 0; p < NP; p++) begin m_ack[d][p] = 1'b0; m_data[d][p] = 32'h0; m_gnt[d][p] = 1'b0; cnt[d][p] = 0; end
      end
      idle_all();
      rst_n = 1'b1;
      apply();
      #1 rst_n = 1'b0;

      // Reset with every port requesting
      set_both(0, 1'b1, 9'h000, 4'hF, 32'hDEADDEAD);
      set_both(1, 1'b1, 9'h100, 4'hF, 32'hFEEDBEEF);
      set_both(2, 1'b1, 9'h104, 4'hF, 32'h12345678);
      step();
      chk("rst_stall", 32'(stall_b[0]), 32'h7);
      chk("rst_ack", 32'(ack_b[1]), 32'h0);
      step();
      rst_n = 1'b1;

      // Parallel banks: port0 bank0, port1 bank1 in the same cycle
      step();
      chk("par_ack_rr", 32'(ack_b[0]), 32'h3);
      chk("par_ack_fp", 32'(ack_b[1]), 32'h3);
      chk("par_d0", rd_b[0][31:0], 32'hDEADDEAD);
      chk("par_d1", rd_b[0][63:32], 32'hFEEDBEEF);
      set_both(0, 1'b0, 9'h000, 4'h0, 32'h0);
      set_both(1, 1'b0, 9'h000, 4'h0, 32'h0);
      step();
      chk("par_p2_late", 32'(ack_b[0]), 32'h4);
      idle_all();

      // Pre-writes for the byte-lane and reset tests
      set_both(1, 1'b1, 9'h103, 4'hF, 32'hFEEDBEEF);
      set_both(2, 1'b1, 9'h014, 4'hF, 32'hA5A5A5A5);
      step();
      idle_all();

      // Byte lanes from two ports to the same word
      set_both(0, 1'b1, 9'h103, 4'b1100, 32'hDEAD0000);
      set_both(1, 1'b1, 9'h103, 4'b0011, 32'h0000BEEF);
      step();
      chk("bl_c1_ack", 32'(ack_b[0]), 32'h1);
      set_both(0, 1'b0, 9'h000, 4'h0, 32'h0);
      step();
      chk("bl_c2_ack", 32'(ack_b[0]), 32'h2);
      idle_all();
      set_both(0, 1'b1, 9'h103, 4'h0, 32'h0);
      step();
      chk("bl_read_rr", rd_b[0][31:0], 32'hDEADBEEF);
      chk("bl_read_fp", rd_b[1][31:0], 32'hDEADBEEF);

      // Port0 streams writes, then async reset between edges
      for (int k = 0; k < 4; k++) begin
         set_both(0, 1'b1, AW'(9'h010 + k), 4'hF, 32'hC0DE0000 + k);
         step();
      end
      rst_n = 1'b0;
      set_both(0, 1'b1, 9'h014, 4'hF, 32'h0BADF00D);
      apply();
      #1;
      chk("arst_ack_drop", 32'(ack_b[0]), 32'h0);
      chk("arst_data_clr", rd_b[0][31:0], 32'h0);
      step();
      step();
      set_both(0, 1'b1, 9'h013, 4'h0, 32'h0);
      rst_n = 1'b1;
      step();
      chk("arst_last_word", rd_b[0][31:0], 32'hC0DE0003);
      set_both(0, 1'b1, 9'h014, 4'h0, 32'h0);
      step();
      chk("arst_no_write", rd_b[0][31:0], 32'hA5A5A5A5);
      idle_all();

      // Fairness / priority: all ports keep reading bank 1
      for (int d = 0; d < 2; d++) for (int p = 0; p < NP; p++) cnt[d][p] = 0;
      for (int p = 0; p < NP; p++) set_both(p, 1'b1, 9'h100, 4'h0, 32'h0);
      for (int k = 0; k < 6; k++) begin
         step();
         v_exp = '0;
         v_exp[k % NP] = 1'b1;
         chk("rr_order", 32'(ack_b[0]), 32'(v_exp));
         chk("fp_order", 32'(ack_b[1]), 32'h1);
      end
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rr_count p%0d", p), 32'(cnt[0][p]), 32'd2);
         chk($sformatf("fp_count p%0d", p), 32'(cnt[1][p]), (p == 0) ? 32'd6 : 32'd0);
      end
      set_both(0, 1'b0, 9'h000, 4'h0, 32'h0);
      step();
      chk("fp_drop_p0", 32'(ack_b[1]), 32'h2);
      idle_all();
      step();

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         rand_cycle();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
